// File: rtl/dbus_responder_pkg.sv
// Shared definitions for the data-bus responder: peripheral base, timer register
// offsets, CTRL/STATUS bit positions and the timer FSM encoding.
package dbus_responder_pkg;

    localparam logic [3:0] PERIPH_BASE_DEF = 4'h1;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_LOAD   = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE   = 2;
    localparam int STAT_PEND = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tmr_state_e;

endpackage

// File: rtl/dbus_timer.sv
// Down-counting timer peripheral: CTRL/LOAD/COUNT/STATUS registers, run FSM and
// level interrupt. Only present when DBUS_TIMER_EN is defined.
module dbus_timer
    import dbus_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] data_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);

    tmr_state_e  state_q, state_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] load_q, load_d;
    logic [31:0] count_q, count_d;
    logic        pend_q, pend_d;
    logic        term;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ctrl_q  <= '0;
            load_q  <= '0;
            count_q <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            load_q  <= load_d;
            count_q <= count_d;
            pend_q  <= pend_d;
        end
    end

    // Bus writes are applied after the FSM so they win; PEND set is applied last.
    always_comb begin
        ctrl_d  = ctrl_q;
        load_d  = load_q;
        count_d = count_q;
        pend_d  = pend_q;
        term    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (count_q != '0) begin
                    count_d = count_q - 32'd1;
                end else begin
                    term = 1'b1;
                    if (ctrl_q[CTRL_AUTO]) count_d = load_q;
                    else                   ctrl_d[CTRL_EN] = 1'b0;
                end
            end
            default: ;
        endcase
        if (wr_i) begin
            case (off_i)
                OFF_CTRL:   ctrl_d = data_i[2:0];
                OFF_LOAD: begin
                    load_d  = data_i;
                    count_d = data_i;
                end
                OFF_STATUS: if (data_i[STAT_PEND]) pend_d = 1'b0;
                default: ;
            endcase
        end
        if (term) pend_d = 1'b1;
        state_d = ctrl_d[CTRL_EN] ? ST_RUN : ST_IDLE;
    end

    always_comb begin
        rdata_o = '0;
        case (off_i)
            OFF_CTRL:   rdata_o = {29'b0, ctrl_q};
            OFF_LOAD:   rdata_o = load_q;
            OFF_COUNT:  rdata_o = count_q;
            OFF_STATUS: rdata_o = {31'b0, pend_q};
            default: ;
        endcase
    end

    assign irq_o = pend_q & ctrl_q[CTRL_IE];

endmodule

// File: rtl/dbus_responder.sv
// Core data-port responder: byte-lane RAM plus an optional timer peripheral.
// The timer is built only when DBUS_TIMER_EN is defined.
module dbus_responder
    import dbus_responder_pkg::*;
#(
    parameter int         RAM_AW      = 10,
    parameter logic [3:0] PERIPH_BASE = PERIPH_BASE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        irq_o
);

    logic [31:0]       mem [2**RAM_AW];
    logic [RAM_AW-1:0] ram_idx;
    logic              is_periph;
    logic [31:0]       ram_rdata;
    logic [31:0]       per_rdata;

    assign ram_idx   = addr_i[RAM_AW+1:2];
    assign is_periph = (addr_i[31:28] == PERIPH_BASE);
    assign ram_rdata = mem[ram_idx];

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ce_i && we_i && !is_periph) begin
            for (int k = 0; k < 4; k++) begin
                if (sel_i[k]) mem[ram_idx][8*k +: 8] <= data_i[8*k +: 8];
            end
        end
    end

`ifdef DBUS_TIMER_EN
    logic        per_map;
    logic        tmr_wr;
    logic [31:0] tmr_rdata;
    logic        unused_ok;

    assign per_map   = (addr_i[27:4] == '0);
    assign tmr_wr    = ce_i & we_i & is_periph & per_map & (sel_i == 4'hF);
    assign per_rdata = per_map ? tmr_rdata : '0;
    assign unused_ok = ^addr_i[1:0];

    dbus_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .wr_i    (tmr_wr),
        .off_i   (addr_i[3:2]),
        .data_i  (data_i),
        .rdata_o (tmr_rdata),
        .irq_o   (irq_o)
    );
`else
    logic unused_ok;

    assign per_rdata = '0;
    assign irq_o     = 1'b0;
    assign unused_ok = ^{rst, addr_i[27:4], addr_i[1:0]};
`endif

    assign data_o = (ce_i && !we_i) ? (is_periph ? per_rdata : ram_rdata) : '0;

endmodule

// File: tb/tb_dbus_responder.sv
// Scoreboard bench for dbus_responder; timer scenarios run when DBUS_TIMER_EN is defined.
module tb_dbus_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [3:0]  sel_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        irq_o;

    dbus_responder dut (
        .clk    (clk),
        .rst    (rst),
        .ce_i   (ce_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .sel_i  (sel_i),
        .data_i (data_i),
        .data_o (data_o),
        .irq_o  (irq_o)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] A_CTRL   = 32'h1000_0000;
    localparam logic [31:0] A_LOAD   = 32'h1000_0004;
    localparam logic [31:0] A_COUNT  = 32'h1000_0008;
    localparam logic [31:0] A_STATUS = 32'h1000_000C;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] act;
    int          mon_kind = 0;   // 0 none, 1 data_o, 2 irq_o
    int          checks = 0;
    int          failures = 0;

    always @(negedge clk) begin
        if (mon_kind != 0) begin
            act = (mon_kind == 2) ? {31'b0, irq_o} : data_o;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty: got %h with nothing expected", act);
            end else begin
                e = sb.pop_front();
                if (act !== e.exp) begin
                    failures++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        ce_i = 1'b0;
        we_i = 1'b0;
        mon_kind = 0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
        ce_i = 1'b1; we_i = 1'b0; addr_i = a; sel_i = 4'hF;
        sb.push_back('{name: nm, exp: exp});
        mon_kind = 1;
        step();
    endtask

    // data_o must read 0 while a write is presented.
    task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input string nm);
        ce_i = 1'b1; we_i = 1'b1; addr_i = a; sel_i = s; data_i = d;
        sb.push_back('{name: {nm, "_wdata_o"}, exp: 32'h0});
        mon_kind = 1;
        step();
    endtask

    task automatic chk_irq(input logic exp, input string nm);
        ce_i = 1'b0;
        sb.push_back('{name: nm, exp: {31'b0, exp}});
        mon_kind = 2;
        step();
    endtask

    task automatic idle(input int n);
        ce_i = 1'b0;
        mon_kind = 0;
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        do_reset();

        // Reset state of the peripheral region and irq.
        rd(A_CTRL,   32'h0, "rst_ctrl");
        rd(A_LOAD,   32'h0, "rst_load");
        rd(A_COUNT,  32'h0, "rst_count");
        rd(A_STATUS, 32'h0, "rst_status");
        rd(32'h1000_0010, 32'h0, "unmapped_off");
        chk_irq(1'b0, "rst_irq");

        // Byte-lane RAM writes, aliasing, full word.
        wr(32'h0, 4'hF, 32'h0, "ram0_clr");
        wr(32'h0, 4'b0100, 32'h00AB_0000, "ram0_lane2");
        rd(32'h0, 32'h00AB_0000, "ram0_lane2_rd");
        wr(32'h0, 4'b0001, 32'h0000_0012, "ram0_lane0");
        rd(32'h0, 32'h00AB_0012, "ram0_lane0_rd");
        rd(32'h0000_1000, 32'h00AB_0012, "ram_alias_rd");
        wr(32'h0000_0006, 4'hF, 32'hDEAD_BEEF, "ram1_full");
        rd(32'h0000_0004, 32'hDEAD_BEEF, "ram1_rd");
        wr(32'h0000_0004, 4'b1010, 32'h1100_2200, "ram1_lanes13");
        rd(32'h0000_0004, 32'h11AD_22EF, "ram1_lanes13_rd");

`ifdef DBUS_TIMER_EN
        // One-shot: LOAD=3, CTRL=EN|IE.
        do_reset();
        wr(A_LOAD, 4'hF, 32'd3, "os_load");
        wr(A_CTRL, 4'hF, 32'h5, "os_ctrl");
        rd(A_COUNT,  32'd3, "os_count3");
        rd(A_COUNT,  32'd2, "os_count2");
        rd(A_COUNT,  32'd1, "os_count1");
        rd(A_STATUS, 32'd0, "os_pend_before");
        rd(A_STATUS, 32'd1, "os_pend_set");
        chk_irq(1'b1, "os_irq");
        rd(A_CTRL,   32'h4, "os_en_cleared");
        rd(A_COUNT,  32'd0, "os_count_hold");

        // Auto-reload: LOAD=2, CTRL=EN|AUTO|IE; W1C collides with terminal count.
        do_reset();
        wr(A_LOAD, 4'hF, 32'd2, "ar_load");
        wr(A_CTRL, 4'hF, 32'h7, "ar_ctrl");
        rd(A_COUNT,  32'd2, "ar_c2a");
        rd(A_COUNT,  32'd1, "ar_c1a");
        rd(A_COUNT,  32'd0, "ar_c0a");
        rd(A_COUNT,  32'd2, "ar_c2b");
        wr(A_STATUS, 4'hF, 32'h1, "ar_w1c");
        rd(A_STATUS, 32'd0, "ar_pend_cleared");
        rd(A_STATUS, 32'd1, "ar_pend_period");
        wr(A_STATUS, 4'hF, 32'h1, "ar_w1c2");
        wr(A_STATUS, 4'hF, 32'h1, "ar_w1c_term");
        rd(A_STATUS, 32'd1, "ar_set_beats_clr");
        rd(A_COUNT,  32'd1, "ar_c1c");
        rd(A_COUNT,  32'd0, "ar_c0c");
        chk_irq(1'b1, "ar_irq");
        rd(A_CTRL,   32'h7, "ar_ctrl_kept");

        // Partial peripheral write is ignored.
        do_reset();
        wr(A_LOAD, 4'b0011, 32'h0000_FFFF, "pw_load");
        rd(A_LOAD,  32'h0, "pw_load_rd");
        rd(A_COUNT, 32'h0, "pw_count_rd");

        // Asynchronous reset mid-count.
        do_reset();
        wr(A_LOAD, 4'hF, 32'd100, "mc_load");
        wr(A_CTRL, 4'hF, 32'h5, "mc_ctrl");
        idle(49);
        rd(A_COUNT, 32'd51, "mc_count51");
        rst = 1'b1;
        rd(A_COUNT,  32'd0, "mc_rst_count");
        rd(A_CTRL,   32'd0, "mc_rst_ctrl");
        rd(A_LOAD,   32'd0, "mc_rst_load");
        rd(A_STATUS, 32'd0, "mc_rst_status");
        chk_irq(1'b0, "mc_rst_irq");
        rd(32'h0000_0004, 32'h11AD_22EF, "mc_ram_kept");
        rst = 1'b0;
`else
        // Timer absent: peripheral reads 0, writes ignored, irq tied low.
        rd(32'h1000_0004, 32'h0, "nt_load_rd");
        wr(A_CTRL, 4'hF, 32'h5, "nt_ctrl");
        wr(A_LOAD, 4'hF, 32'h7, "nt_load");
        idle(5);
        chk_irq(1'b0, "nt_irq");
        rd(A_CTRL,  32'h0, "nt_ctrl_rd");
        rd(A_COUNT, 32'h0, "nt_count_rd");
        rst = 1'b1;
        rd(32'h0000_0004, 32'h11AD_22EF, "nt_ram_kept");
        rst = 1'b0;
`endif

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
